dispatch_queue: RTL and testbench
=================================

# dispatch_queue

Parametrised successor to the single-slot dispatcher. It places an IQ_DEPTH-entry in-order instruction queue between the decoder and the issue back-end, so the decoder keeps fetching while RoB, RS or LSB are full. It resolves operands against RF, RoB and CDB_PORTS broadcast channels, and dispatches at most one instruction per cycle to RoB, RF rename and either RS or LSB. The queue is flushed on a mispredict.

## Interface
- ADDR_WIDTH, 32, PC width
- REG_WIDTH, 5, architectural register index width; NON_REG = 1<<REG_WIDTH on (REG_WIDTH+1)-bit fields
- RoB_WIDTH, 8, RoB index width; Q fields are RoB_WIDTH+1 bits, NON_DEP = 1<<RoB_WIDTH
- IQ_DEPTH, 4, queue entries, power of two, ≥2
- CDB_PORTS, 2, number of CDB broadcast channels

Ports:
- Sys_clk  in  1  clock, all state on rising edge
- Sys_rst  in  1  synchronous active-low reset
- Sys_rdy  in  1  global enable; low = freeze
- DCDP_en  in  1  decoder push valid
- DCDP_pc / DCDP_opcode / DCDP_rs1 / DCDP_rs2 / DCDP_rd / DCDP_imm / DCDP_predict_result  in  ADDR_WIDTH/7/REG_WIDTH×3/32/1  decoded instruction
- DPDC_ready  out  1  queue accepts a push this cycle
- DPRF_rs1, DPRF_rs2  out  REG_WIDTH+1  head source regs, masked to NON_REG when unused
- RFDP_Qj, RFDP_Qk  in  RoB_WIDTH+1; RFDP_Vj, RFDP_Vk  in  32  RF lookup
- DPRoB_Qj, DPRoB_Qk  out  RoB_WIDTH+1  = RFDP_Qj/Qk
- RoBDP_Qj_ready, RoBDP_Qk_ready  in  1; RoBDP_Vj, RoBDP_Vk  in  32  RoB value lookup
- RoBDP_full  in  1; RoBDP_RoB_index  in  RoB_WIDTH  next free RoB slot
- RoBDP_pre_judge  in  1  0 = mispredict (flush)
- RSDP_full, LSBDP_full  in  1
- CDBDP_en  in  CDB_PORTS; CDBDP_RoB_index  in  CDB_PORTS*RoB_WIDTH; CDBDP_value  in  CDB_PORTS*32  channel i at slice i
- DPRF_en, DPRF_rd, DPRF_RoB_index  out  1/REG_WIDTH+1/RoB_WIDTH  rename write
- DPRoB_en, DPRoB_pc, DPRoB_opcode, DPRoB_rd, DPRoB_predict_result  out  RoB allocate
- DPRS_en, DPRS_pc, DPRS_opcode, DPRS_imm, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_RoB_index  out  RS issue
- DPLSB_en, DPLSB_opcode, DPLSB_imm, DPLSB_Qj, DPLSB_Qk, DPLSB_Vj, DPLSB_Vk, DPLSB_RoB_index  out  LSB issue
- DPDC_count  out  $clog2(IQ_DEPTH)+1  occupancy

## Operation
- Circular queue with head/tail pointers of $clog2(IQ_DEPTH) bits plus a count register; pointers wrap modulo IQ_DEPTH.
- Push: DCDP_en && DPDC_ready at the edge. DPDC_ready = (count < IQ_DEPTH), from the registered count only. A full queue does not accept a push even if a pop occurs in the same cycle.
- Opcode enumeration is the shared decoder encoding (lui=1 … andd=37). isLS = lb..sw (11–18).
- Source masking: rs1 → NON_REG for lui/auipc/jal. rs2 → NON_REG for lui/auipc/jal/jalr/loads/I-type ALU.
- rd → NON_REG for branches and stores.
- Operand resolution for each of j and k, in priority order:
  - RF Q == NON_DEP: V = RF V.
  - Else if RoB ready: V = RoB V.
  - Else if the lowest-index CDB channel i matches (en[i] && index == Q): V = value[i].
  - Otherwise keep Q and RF V.
  - Resolved fields output Q = NON_DEP.
- Dispatch condition: head valid && !RoBDP_full && !(isLS ? LSBDP_full : RSDP_full).
- On dispatch:
  - Pop the head.
  - Register payloads.
  - Pulse DPRF_en, DPRoB_en and exactly one of DPRS_en/DPLSB_en for one cycle.
  - All RoB-index fields = RoBDP_RoB_index.
- When no dispatch occurs, all *_en = 0 and payload registers hold.
- Flush (RoBDP_pre_judge == 0), priority below reset and above Sys_rdy:
  - count, head and tail are zeroed.
  - All *_en = 0.
  - A same-cycle push is discarded.
- Sys_rdy == 0: no push, no pop, all *_en = 0, queue contents held.
- Reset: count/pointers 0; all *_en 0; Q outputs NON_DEP; V, imm, pc, opcode, RoB_index outputs 0; DPRF_rd/DPRoB_rd NON_REG.

## Timing
- Push at edge T. The entry is the head during cycle T+1 at the earliest. Dispatch at edge T+1 gives *_en high during T+1..T+2. Minimum decoder-to-issue latency is 1 cycle.
- Throughput: one push and one pop per cycle.
- A stalled head blocks younger entries; there is no reordering.
- DPDC_ready, DPRF_rs1/rs2 and DPRoB_Qj/Qk are combinational from registered state. Resolution is combinational within the dispatch cycle.

## Configuration
- DP_BYPASS_EN defined:
  - A push into an empty queue whose dispatch condition holds that cycle dispatches at the same edge.
  - The entry is not written to the queue.
  - DPRF_rs1/rs2 are sourced from the DCDP_* inputs while the queue is empty.
  - Latency is 0 cycles.
- Undefined: every instruction spends at least one cycle in the queue; DPRF_rs1/rs2 are sourced only from the head.

## Test plan
- Reset low 2 cycles → all *_en 0, DPDC_count 0, DPDC_ready 1, DPRS_Qj = 9'h100.
- Push addi rd=5 rs1=3 (RF Q=NON_DEP, V=7), RoB index 12 → next cycle DPRS_en=1, Vj=7, Qj=NON_DEP, DPRF_rd=5, DPRF_RoB_index=12, DPLSB_en=0.
- RoBDP_full high, 5 pushes with IQ_DEPTH=4 → 4 accepted, DPDC_ready 0. Release full → 4 dispatches on consecutive cycles in push order.
- Head sw with RFDP_Qk=9'd3, not RoB-ready, CDB channel 1 broadcasting index 3 value 0xDEAD → DPLSB_Qk=NON_DEP, DPLSB_Vk=0xDEAD, DPRF_rd=NON_REG.
- 3 entries queued, RoBDP_pre_judge=0 with a simultaneous push → next cycle DPDC_count 0, no *_en pulses, the pushed instruction never dispatched.
- With DP_BYPASS_EN, push lui into an empty queue → *_en high the cycle after the push edge. Without it, one cycle later.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order instruction queue with operand resolution and single issue; `DP_BYPASS_EN lets a push into an empty queue dispatch at the same edge
module dispatch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 5,
  parameter int RoB_WIDTH  = 8,
  parameter int IQ_DEPTH   = 4,
  parameter int CDB_PORTS  = 2
) (
  input  logic                            Sys_clk,
  input  logic                            Sys_rst,
  input  logic                            Sys_rdy,
  input  logic                            DCDP_en,
  input  logic [ADDR_WIDTH-1:0]           DCDP_pc,
  input  logic [6:0]                      DCDP_opcode,
  input  logic [REG_WIDTH-1:0]            DCDP_rs1,
  input  logic [REG_WIDTH-1:0]            DCDP_rs2,
  input  logic [REG_WIDTH-1:0]            DCDP_rd,
  input  logic [31:0]                     DCDP_imm,
  input  logic                            DCDP_predict_result,
  output logic                            DPDC_ready,
  output logic [$clog2(IQ_DEPTH):0]       DPDC_count,
  output logic [REG_WIDTH:0]              DPRF_rs1,
  output logic [REG_WIDTH:0]              DPRF_rs2,
  input  logic [RoB_WIDTH:0]              RFDP_Qj,
  input  logic [RoB_WIDTH:0]              RFDP_Qk,
  input  logic [31:0]                     RFDP_Vj,
  input  logic [31:0]                     RFDP_Vk,
  output logic [RoB_WIDTH:0]              DPRoB_Qj,
  output logic [RoB_WIDTH:0]              DPRoB_Qk,
  input  logic                            RoBDP_Qj_ready,
  input  logic                            RoBDP_Qk_ready,
  input  logic [31:0]                     RoBDP_Vj,
  input  logic [31:0]                     RoBDP_Vk,
  input  logic                            RoBDP_full,
  input  logic [RoB_WIDTH-1:0]            RoBDP_RoB_index,
  input  logic                            RoBDP_pre_judge,
  input  logic                            RSDP_full,
  input  logic                            LSBDP_full,
  input  logic [CDB_PORTS-1:0]            CDBDP_en,
  input  logic [CDB_PORTS*RoB_WIDTH-1:0]  CDBDP_RoB_index,
  input  logic [CDB_PORTS*32-1:0]         CDBDP_value,
  output logic                            DPRF_en,
  output logic [REG_WIDTH:0]              DPRF_rd,
  output logic [RoB_WIDTH-1:0]            DPRF_RoB_index,
  output logic                            DPRoB_en,
  output logic [ADDR_WIDTH-1:0]           DPRoB_pc,
  output logic [6:0]                      DPRoB_opcode,
  output logic [REG_WIDTH:0]              DPRoB_rd,
  output logic                            DPRoB_predict_result,
  output logic                            DPRS_en,
  output logic [ADDR_WIDTH-1:0]           DPRS_pc,
  output logic [6:0]                      DPRS_opcode,
  output logic [31:0]                     DPRS_imm,
  output logic [RoB_WIDTH:0]              DPRS_Qj,
  output logic [RoB_WIDTH:0]              DPRS_Qk,
  output logic [31:0]                     DPRS_Vj,
  output logic [31:0]                     DPRS_Vk,
  output logic [RoB_WIDTH-1:0]            DPRS_RoB_index,
  output logic                            DPLSB_en,
  output logic [6:0]                      DPLSB_opcode,
  output logic [31:0]                     DPLSB_imm,
  output logic [RoB_WIDTH:0]              DPLSB_Qj,
  output logic [RoB_WIDTH:0]              DPLSB_Qk,
  output logic [31:0]                     DPLSB_Vj,
  output logic [31:0]                     DPLSB_Vk,
  output logic [RoB_WIDTH-1:0]            DPLSB_RoB_index
);
  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + 7 + 3 * REG_WIDTH + 32 + 1;
  localparam logic [REG_WIDTH:0] NON_REG = {1'b1, {REG_WIDTH{1'b0}}};
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};
`ifdef DP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic [EW-1:0] mem_q [IQ_DEPTH];
  logic [PW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] in_ent, hd_ent;
  logic [ADDR_WIDTH-1:0] hd_pc;
  logic [6:0] hd_op;
  logic [REG_WIDTH-1:0] hd_rs1, hd_rs2, hd_rd;
  logic [31:0] hd_imm;
  logic hd_pred, hd_valid, is_ls, go, push, disp, wr, pop;
  logic [RoB_WIDTH+32:0] res_j, res_k;
  logic en_q, rs_en_q, lsb_en_q, pred_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [6:0] op_q;
  logic [31:0] imm_q, vj_q, vk_q;
  logic [REG_WIDTH:0] rd_q;
  logic [RoB_WIDTH:0] qj_q, qk_q;
  logic [RoB_WIDTH-1:0] rob_q;
  // Priority: no dependency, then RoB value, then the lowest-index matching CDB channel
  function automatic logic [RoB_WIDTH+32:0] resolve(input logic [RoB_WIDTH:0] q, input logic [31:0] v,
                                                   input logic rob_rdy, input logic [31:0] rob_v);
    logic [RoB_WIDTH+32:0] r;
    r = {q, v};
    for (int i = CDB_PORTS - 1; i >= 0; i--)
      if (CDBDP_en[i] && {1'b0, CDBDP_RoB_index[i*RoB_WIDTH +: RoB_WIDTH]} == q)
        r = {NON_DEP, CDBDP_value[i*32 +: 32]};
    if (rob_rdy) r = {NON_DEP, rob_v};
    if (q == NON_DEP) r = {NON_DEP, v};
    return r;
  endfunction
  assign in_ent = {DCDP_pc, DCDP_opcode, DCDP_rs1, DCDP_rs2, DCDP_rd, DCDP_imm, DCDP_predict_result};
  assign hd_ent = (BYP && count_q == '0) ? in_ent : mem_q[head_q];
  assign {hd_pc, hd_op, hd_rs1, hd_rs2, hd_rd, hd_imm, hd_pred} = hd_ent;
  assign hd_valid = count_q != '0 || (BYP && DCDP_en);
  assign is_ls = hd_op >= 7'd11 && hd_op <= 7'd18;
  assign DPDC_ready = count_q < CW'(IQ_DEPTH);
  assign DPDC_count = count_q;
  assign DPRF_rs1 = (hd_op inside {[7'd1:7'd3]}) ? NON_REG : {1'b0, hd_rs1};
  assign DPRF_rs2 = (hd_op inside {[7'd1:7'd4], [7'd11:7'd15], [7'd19:7'd27]}) ? NON_REG : {1'b0, hd_rs2};
  assign DPRoB_Qj = RFDP_Qj;
  assign DPRoB_Qk = RFDP_Qk;
  assign res_j = resolve(RFDP_Qj, RFDP_Vj, RoBDP_Qj_ready, RoBDP_Vj);
  assign res_k = resolve(RFDP_Qk, RFDP_Vk, RoBDP_Qk_ready, RoBDP_Vk);
  assign go = Sys_rdy && RoBDP_pre_judge;
  assign push = go && DCDP_en && DPDC_ready;
  assign disp = go && hd_valid && !RoBDP_full && !(is_ls ? LSBDP_full : RSDP_full);
  assign pop = disp && count_q != '0;
  // A bypassed push is consumed directly and never occupies a slot
  assign wr = push && !(BYP && count_q == '0 && disp);
  assign count_d = count_q + CW'(wr) - CW'(pop);
  assign head_d = head_q + PW'(pop);
  assign tail_d = tail_q + PW'(wr);
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      count_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      en_q <= 1'b0;
      rs_en_q <= 1'b0;
      lsb_en_q <= 1'b0;
      pc_q <= '0;
      op_q <= '0;
      imm_q <= '0;
      rd_q <= NON_REG;
      pred_q <= 1'b0;
      qj_q <= NON_DEP;
      qk_q <= NON_DEP;
      vj_q <= '0;
      vk_q <= '0;
      rob_q <= '0;
    end else begin
      count_q <= RoBDP_pre_judge ? count_d : '0;
      head_q <= RoBDP_pre_judge ? head_d : '0;
      tail_q <= RoBDP_pre_judge ? tail_d : '0;
      en_q <= disp;
      rs_en_q <= disp && !is_ls;
      lsb_en_q <= disp && is_ls;
      if (disp) begin
        pc_q <= hd_pc;
        op_q <= hd_op;
        imm_q <= hd_imm;
        rd_q <= (hd_op inside {[7'd5:7'd10], [7'd16:7'd18]}) ? NON_REG : {1'b0, hd_rd};
        pred_q <= hd_pred;
        {qj_q, vj_q} <= res_j;
        {qk_q, vk_q} <= res_k;
        rob_q <= RoBDP_RoB_index;
      end
    end
  end
  always_ff @(posedge Sys_clk)
    if (Sys_rst && wr) mem_q[tail_q] <= in_ent;
  assign DPRF_en = en_q;
  assign DPRF_rd = rd_q;
  assign DPRF_RoB_index = rob_q;
  assign DPRoB_en = en_q;
  assign DPRoB_pc = pc_q;
  assign DPRoB_opcode = op_q;
  assign DPRoB_rd = rd_q;
  assign DPRoB_predict_result = pred_q;
  assign DPRS_en = rs_en_q;
  assign DPRS_pc = pc_q;
  assign DPRS_opcode = op_q;
  assign DPRS_imm = imm_q;
  assign DPRS_Qj = qj_q;
  assign DPRS_Qk = qk_q;
  assign DPRS_Vj = vj_q;
  assign DPRS_Vk = vk_q;
  assign DPRS_RoB_index = rob_q;
  assign DPLSB_en = lsb_en_q;
  assign DPLSB_opcode = op_q;
  assign DPLSB_imm = imm_q;
  assign DPLSB_Qj = qj_q;
  assign DPLSB_Qk = qk_q;
  assign DPLSB_Vj = vj_q;
  assign DPLSB_Vk = vk_q;
  assign DPLSB_RoB_index = rob_q;
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed stimulus with a scoreboard of expected dispatches checked by a monitor
module tb_dispatch_queue;
  localparam logic [8:0] ND = 9'h100;
  localparam logic [5:0] NR = 6'h20;
`ifdef DP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic Sys_clk = 1'b0, Sys_rst = 1'b0, Sys_rdy = 1'b1;
  logic DCDP_en = 1'b0, DCDP_predict_result = 1'b0;
  logic [31:0] DCDP_pc = '0, DCDP_imm = '0;
  logic [6:0] DCDP_opcode = '0;
  logic [4:0] DCDP_rs1 = '0, DCDP_rs2 = '0, DCDP_rd = '0;
  logic DPDC_ready;
  logic [2:0] DPDC_count;
  logic [5:0] DPRF_rs1, DPRF_rs2, DPRF_rd, DPRoB_rd;
  logic [8:0] RFDP_Qj, RFDP_Qk, DPRoB_Qj, DPRoB_Qk, DPRS_Qj, DPRS_Qk, DPLSB_Qj, DPLSB_Qk;
  logic [31:0] RFDP_Vj, RFDP_Vk, RoBDP_Vj, RoBDP_Vk;
  logic RoBDP_Qj_ready, RoBDP_Qk_ready;
  logic RoBDP_full = 1'b0, RoBDP_pre_judge = 1'b1, RSDP_full = 1'b0, LSBDP_full = 1'b0;
  logic [7:0] RoBDP_RoB_index = '0;
  logic [1:0] CDBDP_en;
  logic [15:0] CDBDP_RoB_index;
  logic [63:0] CDBDP_value;
  logic DPRF_en, DPRoB_en, DPRoB_predict_result, DPRS_en, DPLSB_en;
  logic [7:0] DPRF_RoB_index, DPRS_RoB_index, DPLSB_RoB_index;
  logic [31:0] DPRoB_pc, DPRS_pc, DPRS_imm, DPRS_Vj, DPRS_Vk, DPLSB_imm, DPLSB_Vj, DPLSB_Vk;
  logic [6:0] DPRoB_opcode, DPRS_opcode, DPLSB_opcode;

  dispatch_queue dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .DCDP_en(DCDP_en), .DCDP_pc(DCDP_pc), .DCDP_opcode(DCDP_opcode), .DCDP_rs1(DCDP_rs1),
    .DCDP_rs2(DCDP_rs2), .DCDP_rd(DCDP_rd), .DCDP_imm(DCDP_imm), .DCDP_predict_result(DCDP_predict_result),
    .DPDC_ready(DPDC_ready), .DPDC_count(DPDC_count), .DPRF_rs1(DPRF_rs1), .DPRF_rs2(DPRF_rs2),
    .RFDP_Qj(RFDP_Qj), .RFDP_Qk(RFDP_Qk), .RFDP_Vj(RFDP_Vj), .RFDP_Vk(RFDP_Vk),
    .DPRoB_Qj(DPRoB_Qj), .DPRoB_Qk(DPRoB_Qk), .RoBDP_Qj_ready(RoBDP_Qj_ready), .RoBDP_Qk_ready(RoBDP_Qk_ready),
    .RoBDP_Vj(RoBDP_Vj), .RoBDP_Vk(RoBDP_Vk), .RoBDP_full(RoBDP_full), .RoBDP_RoB_index(RoBDP_RoB_index),
    .RoBDP_pre_judge(RoBDP_pre_judge), .RSDP_full(RSDP_full), .LSBDP_full(LSBDP_full),
    .CDBDP_en(CDBDP_en), .CDBDP_RoB_index(CDBDP_RoB_index), .CDBDP_value(CDBDP_value),
    .DPRF_en(DPRF_en), .DPRF_rd(DPRF_rd), .DPRF_RoB_index(DPRF_RoB_index),
    .DPRoB_en(DPRoB_en), .DPRoB_pc(DPRoB_pc), .DPRoB_opcode(DPRoB_opcode), .DPRoB_rd(DPRoB_rd),
    .DPRoB_predict_result(DPRoB_predict_result),
    .DPRS_en(DPRS_en), .DPRS_pc(DPRS_pc), .DPRS_opcode(DPRS_opcode), .DPRS_imm(DPRS_imm),
    .DPRS_Qj(DPRS_Qj), .DPRS_Qk(DPRS_Qk), .DPRS_Vj(DPRS_Vj), .DPRS_Vk(DPRS_Vk), .DPRS_RoB_index(DPRS_RoB_index),
    .DPLSB_en(DPLSB_en), .DPLSB_opcode(DPLSB_opcode), .DPLSB_imm(DPLSB_imm),
    .DPLSB_Qj(DPLSB_Qj), .DPLSB_Qk(DPLSB_Qk), .DPLSB_Vj(DPLSB_Vj), .DPLSB_Vk(DPLSB_Vk),
    .DPLSB_RoB_index(DPLSB_RoB_index)
  );

  always #5 Sys_clk = ~Sys_clk;

  typedef struct {
    logic ls; logic [31:0] pc; logic [6:0] op; logic [5:0] rd; logic [31:0] imm;
    logic [8:0] qj; logic [31:0] vj; logic [8:0] qk; logic [31:0] vk; logic [7:0] rob; logic pred;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [181:0] got, want;
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] g, input logic [63:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, g, w);
    end
  endtask

  task automatic exp_disp(input logic ls, input logic [31:0] pc, input logic [6:0] op, input logic [5:0] rd,
                          input logic [31:0] imm, input logic [8:0] qj, input logic [31:0] vj,
                          input logic [8:0] qk, input logic [31:0] vk, input logic [7:0] rob, input logic pred);
    sb.push_back('{ls, pc, op, rd, imm, qj, vj, qk, vk, rob, pred});
  endtask

  task automatic set_ins(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] imm, input logic pred);
    DCDP_pc = pc; DCDP_opcode = op; DCDP_rs1 = rs1; DCDP_rs2 = rs2;
    DCDP_rd = rd; DCDP_imm = imm; DCDP_predict_result = pred;
  endtask

  task automatic defaults();
    RFDP_Qj = ND; RFDP_Qk = ND; RFDP_Vj = '0; RFDP_Vk = '0;
    RoBDP_Qj_ready = 1'b0; RoBDP_Qk_ready = 1'b0; RoBDP_Vj = '0; RoBDP_Vk = '0;
    CDBDP_en = '0; CDBDP_RoB_index = '0; CDBDP_value = '0;
  endtask

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic single(input int cycles);
    DCDP_en = 1'b1;
    step();
    DCDP_en = 1'b0;
    repeat (cycles) step();
  endtask

  always @(negedge Sys_clk) begin
    if (Sys_rst && (DPRS_en || DPLSB_en)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dispatch got pc=%h required no dispatch", DPRoB_pc);
      end else begin
        e = sb.pop_front();
        check("dispatch_en", {DPRF_en, DPRoB_en, DPRS_en, DPLSB_en}, {1'b1, 1'b1, !e.ls, e.ls});
        got = e.ls ? {DPRoB_pc, DPLSB_opcode, DPRF_rd, DPRoB_rd, DPLSB_imm, DPLSB_Qj, DPLSB_Vj, DPLSB_Qk, DPLSB_Vk,
                      DPLSB_RoB_index, DPRF_RoB_index, DPRoB_predict_result}
                   : {DPRS_pc, DPRS_opcode, DPRF_rd, DPRoB_rd, DPRS_imm, DPRS_Qj, DPRS_Vj, DPRS_Qk, DPRS_Vk,
                      DPRS_RoB_index, DPRF_RoB_index, DPRoB_predict_result};
        want = {e.pc, e.op, e.rd, e.rd, e.imm, e.qj, e.vj, e.qk, e.vk, e.rob, e.rob, e.pred};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL dispatch_payload pc=%h got=%h required=%h", e.pc, got, want);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    defaults();
    step();
    step();
    check("rst_en", {DPRF_en, DPRoB_en, DPRS_en, DPLSB_en}, 4'b0000);
    check("rst_count", DPDC_count, 3'd0);
    check("rst_ready", DPDC_ready, 1'b1);
    check("rst_qj", DPRS_Qj, ND);
    check("rst_rd", DPRF_rd, NR);
    Sys_rst = 1'b1;
    step();
    // addi rd=5 rs1=3, operand ready in RF
    defaults();
    RFDP_Vj = 32'd7;
    RoBDP_RoB_index = 8'd12;
    exp_disp(1'b0, 32'h100, 7'd19, 6'd5, 32'd4, ND, 32'd7, ND, 32'd0, 8'd12, 1'b1);
    set_ins(32'h100, 7'd19, 5'd3, 5'd0, 5'd5, 32'd4, 1'b1);
    DCDP_en = 1'b1;
    step();
    DCDP_en = 1'b0;
    check("addi_rs1", DPRF_rs1, 6'd3);
    check("addi_rs2_masked", DPRF_rs2, NR);
    repeat (3) step();
    // back-pressure: 5 pushes into a 4-deep queue while RoB is full
    defaults();
    RFDP_Vj = 32'h11;
    RFDP_Vk = 32'h22;
    RoBDP_RoB_index = 8'd20;
    RoBDP_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_disp(1'b0, 32'h200 + 32'(4 * i), 7'd28, 6'(i + 1), 32'd0, ND, 32'h11, ND, 32'h22, 8'd20, 1'b0);
      set_ins(32'h200 + 32'(4 * i), 7'd28, 5'd1, 5'd2, 5'(i + 1), 32'd0, 1'b0);
      DCDP_en = 1'b1;
      step();
    end
    DCDP_en = 1'b0;
    check("full_count", DPDC_count, 3'd4);
    check("full_ready", DPDC_ready, 1'b0);
    RoBDP_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("drain_consecutive", DPRS_en, 1'b1);
    end
    step();
    check("drain_done_en", DPRS_en, 1'b0);
    check("drain_done_count", DPDC_count, 3'd0);
    // sw: rs2 resolved from CDB channel 1, channel 0 carries another tag
    defaults();
    RoBDP_RoB_index = 8'd30;
    RFDP_Vj = 32'h1000;
    RFDP_Qk = 9'd3;
    RFDP_Vk = 32'h55;
    CDBDP_en = 2'b11;
    CDBDP_RoB_index = {8'd3, 8'd4};
    CDBDP_value = {32'hDEAD, 32'hBEEF};
    exp_disp(1'b1, 32'h300, 7'd18, NR, 32'd8, ND, 32'h1000, ND, 32'hDEAD, 8'd30, 1'b0);
    set_ins(32'h300, 7'd18, 5'd2, 5'd3, 5'd0, 32'd8, 1'b0);
    single(3);
    // lw: RoB-ready value wins over a matching CDB channel
    defaults();
    RoBDP_RoB_index = 8'd31;
    RFDP_Qj = 9'd5;
    RFDP_Vj = 32'h1;
    RoBDP_Qj_ready = 1'b1;
    RoBDP_Vj = 32'h77;
    RFDP_Vk = 32'h9;
    CDBDP_en = 2'b01;
    CDBDP_RoB_index = {8'd0, 8'd5};
    CDBDP_value = {32'h0, 32'hAAAA};
    exp_disp(1'b1, 32'h304, 7'd13, 6'd7, 32'd16, ND, 32'h77, ND, 32'h9, 8'd31, 1'b0);
    set_ins(32'h304, 7'd13, 5'd4, 5'd0, 5'd7, 32'd16, 1'b0);
    single(3);
    // add: both channels match j (lowest wins), k stays unresolved
    defaults();
    RoBDP_RoB_index = 8'd32;
    RFDP_Qj = 9'd6;
    RFDP_Vj = 32'h1;
    RFDP_Qk = 9'd9;
    RFDP_Vk = 32'h33;
    CDBDP_en = 2'b11;
    CDBDP_RoB_index = {8'd6, 8'd6};
    CDBDP_value = {32'h2222, 32'h1111};
    exp_disp(1'b0, 32'h308, 7'd28, 6'd8, 32'd0, ND, 32'h1111, 9'd9, 32'h33, 8'd32, 1'b0);
    set_ins(32'h308, 7'd28, 5'd1, 5'd2, 5'd8, 32'd0, 1'b0);
    single(3);
    // mispredict flush with a simultaneous push
    defaults();
    RoBDP_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ins(32'h400 + 32'(4 * i), 7'd28, 5'd1, 5'd2, 5'd1, 32'd0, 1'b0);
      DCDP_en = 1'b1;
      step();
    end
    set_ins(32'h4F0, 7'd28, 5'd1, 5'd2, 5'd1, 32'd0, 1'b0);
    RoBDP_pre_judge = 1'b0;
    step();
    DCDP_en = 1'b0;
    RoBDP_pre_judge = 1'b1;
    check("flush_count", DPDC_count, 3'd0);
    RoBDP_full = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_en", {DPRF_en, DPRoB_en, DPRS_en, DPLSB_en}, 4'b0000);
    end
    // frozen: push ignored
    Sys_rdy = 1'b0;
    set_ins(32'h600, 7'd1, 5'd0, 5'd0, 5'd9, 32'd0, 1'b0);
    DCDP_en = 1'b1;
    step();
    DCDP_en = 1'b0;
    check("rdy_no_push", DPDC_count, 3'd0);
    Sys_rdy = 1'b1;
    step();
    check("rdy_no_disp", {DPRF_en, DPRS_en, DPLSB_en}, 3'b000);
    // latency: lui into an empty queue
    defaults();
    RoBDP_RoB_index = 8'd40;
    exp_disp(1'b0, 32'h500, 7'd1, 6'd9, 32'h12345000, ND, 32'd0, ND, 32'd0, 8'd40, 1'b0);
    set_ins(32'h500, 7'd1, 5'd0, 5'd0, 5'd9, 32'h12345000, 1'b0);
    DCDP_en = 1'b1;
    step();
    DCDP_en = 1'b0;
    check("lat_first", DPRS_en, BYP);
    step();
    check("lat_second", DPRS_en, !BYP);
    repeat (2) step();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
